// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared UART types and default sizing
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int C_DEFAULT_N     = 8;
  localparam int C_DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo : single-clock circular FIFO with flush, shared by Tx and Rx
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int N     = C_DEFAULT_N,
  parameter int DEPTH = C_DEFAULT_DEPTH
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [N-1:0]             wdata,
  input  logic                     pop,
  output logic [N-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [N-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  // A full FIFO rejects the push even when a pop happens in the same cycle.
  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty & ~flush;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + C_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + C_PTR_ONE;
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

  assign rdata = r_mem[r_rptr[AW-1:0]];
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign level = r_wptr - r_rptr;

endmodule

`default_nettype wire

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder : buffers bytes and hands them one at a time to a UART Tx
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int N     = C_DEFAULT_N,
  parameter int DEPTH = C_DEFAULT_DEPTH
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     wr_en,
  input  logic [N-1:0]             wr_data,
  input  logic                     flush,
  input  logic                     ovf_clr,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic [N-1:0]             tx_data,
  output logic                     tx_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  tx_state_t    r_state;
  tx_state_t    w_state_nxt;
  logic         r_tx_en;
  logic         w_tx_en_nxt;
  logic [N-1:0] r_tx_data;
  logic [N-1:0] w_head;
  logic         w_pop;
  logic         r_overflow;
  logic         w_ovf_set;

  uart_sync_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .flush   (flush),
    .push    (wr_en),
    .wdata   (wr_data),
    .pop     (w_pop),
    .rdata   (w_head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tx_en_nxt = r_tx_en;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!empty && !tx_busy && !flush) begin
          w_pop       = 1'b1;
          w_tx_en_nxt = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (flush) begin
          w_tx_en_nxt = 1'b0;
          w_state_nxt = IDLE;
        end else if (tx_busy) begin
          w_tx_en_nxt = 1'b0;
          w_state_nxt = WAIT;
        end
      end
      // An in-flight byte always runs to completion, even across a flush.
      WAIT: begin
        if (tx_done) w_state_nxt = IDLE;
      end
      default: begin
        w_tx_en_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= IDLE;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tx_en <= w_tx_en_nxt;
      if (w_pop) r_tx_data <= w_head;
    end
  end

  // Flush discards a concurrent push silently; a rejected push beats ovf_clr.
  assign w_ovf_set = wr_en & full & ~flush;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)       r_overflow <= 1'b0;
    else if (w_ovf_set) r_overflow <= 1'b1;
    else if (ovf_clr)   r_overflow <= 1'b0;
  end

  assign tx_en    = r_tx_en;
  assign tx_data  = r_tx_data;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_feeder : vector table, directed corner sequences, random vs model
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_feeder;

  localparam int N     = 8;
  localparam int DEPTH = 16;

  logic       PCLK;
  logic       PRESETn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       ovf_clr;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx_feeder #(.N(N), .DEPTH(DEPTH)) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .ovf_clr  (ovf_clr),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  typedef struct packed {
    logic       we;
    logic [7:0] wd;
    logic       fl;
    logic       oc;
    logic       busy;
    logic       done;
    logic [4:0] lvl;
    logic       txen;
    logic [7:0] txd;
    logic       ovf;
    logic       emp;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic cyc(input logic we, input logic [7:0] wd, input logic fl,
                     input logic oc, input logic busy, input logic done);
    wr_en   = we;
    wr_data = wd;
    flush   = fl;
    ovf_clr = oc;
    tx_busy = busy;
    tx_done = done;
    @(posedge PCLK);
    #1;
  endtask

  // Transmitter-driven sequence bookkeeping
  logic [7:0] got [$];
  int         bc;
  int         bad_order;
  logic       done_seen;
  logic       prev_en;
  logic       pulse;
  logic       seen;

  // Reference model state
  logic [7:0] mq [$];
  int         ms;          // 0 idle, 1 presenting, 2 byte in flight
  logic       mtxen;
  logic       movf;
  logic [7:0] mtxd;
  logic       mfull;
  logic       mempty;
  logic       mpop;
  logic [4:0] mlvl;

  initial begin
    PRESETn = 1'b0;
    wr_en = 0; wr_data = 0; flush = 0; ovf_clr = 0; tx_busy = 0; tx_done = 0;
    #12;
    chk("rst.tx_en", tx_en, 0);
    chk("rst.tx_data", tx_data, 0);
    chk("rst.level", level, 0);
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.overflow", overflow, 0);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;

    //          we    wd     fl    oc    busy  done  lvl   txen  txd    ovf   emp
    vt[0]  = {1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[1]  = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 8'h55, 1'b0, 1'b1};
    vt[2]  = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 8'h55, 1'b0, 1'b1};
    vt[3]  = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h55, 1'b0, 1'b1};
    vt[4]  = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h55, 1'b0, 1'b1};
    vt[5]  = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'h55, 1'b0, 1'b1};
    vt[6]  = {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 8'h55, 1'b0, 1'b1};
    vt[7]  = {1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 8'h55, 1'b0, 1'b0};
    vt[8]  = {1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA1, 1'b0, 1'b0};
    vt[9]  = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 8'hA1, 1'b0, 1'b0};
    vt[10] = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 8'hA1, 1'b0, 1'b0};
    vt[11] = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 8'hB2, 1'b0, 1'b1};
    vt[12] = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'hB2, 1'b0, 1'b1};
    vt[13] = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'hB2, 1'b0, 1'b1};

    for (int i = 0; i < 14; i++) begin
      cyc(vt[i].we, vt[i].wd, vt[i].fl, vt[i].oc, vt[i].busy, vt[i].done);
      chk($sformatf("vec%0d.level", i), level, vt[i].lvl);
      chk($sformatf("vec%0d.tx_en", i), tx_en, vt[i].txen);
      chk($sformatf("vec%0d.tx_data", i), tx_data, vt[i].txd);
      chk($sformatf("vec%0d.overflow", i), overflow, vt[i].ovf);
      chk($sformatf("vec%0d.empty", i), empty, vt[i].emp);
    end

    // Three bytes through a transmitter model: busy 3 cycles then a done pulse
    cyc(1, 8'hA1, 0, 0, 1, 0);
    cyc(1, 8'hB2, 0, 0, 1, 0);
    cyc(1, 8'hC3, 0, 0, 1, 0);
    chk("seq3.level", level, 3);
    wr_en = 0; tx_busy = 0; tx_done = 0;
    bc = 0; bad_order = 0; done_seen = 1; prev_en = 0;
    for (int k = 0; k < 60; k++) begin
      if (tx_busy) begin
        bc++;
        if (bc == 3) begin tx_busy = 0; tx_done = 1; end
      end else begin
        tx_done = 0;
        if (tx_en) begin tx_busy = 1; bc = 0; end
      end
      pulse = tx_done;
      @(posedge PCLK);
      #1;
      if (tx_en && !prev_en) begin
        if (!done_seen) bad_order++;
        done_seen = 0;
        got.push_back(tx_data);
      end
      if (pulse) done_seen = 1;
      prev_en = tx_en;
    end
    chk("seq3.count", got.size(), 3);
    chk("seq3.byte0", got.size() > 0 ? got[0] : 8'hEE, 8'hA1);
    chk("seq3.byte1", got.size() > 1 ? got[1] : 8'hEE, 8'hB2);
    chk("seq3.byte2", got.size() > 2 ? got[2] : 8'hEE, 8'hC3);
    chk("seq3.order", bad_order, 0);
    chk("seq3.empty", empty, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // Fill to full, overflow behaviour
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 1, 0);
    chk("fill.level", level, 16);
    chk("fill.full", full, 1);
    cyc(1, 8'hAA, 0, 0, 1, 0);
    chk("ovf.set", overflow, 1);
    chk("ovf.level", level, 16);
    cyc(0, 0, 0, 1, 1, 0);
    chk("ovf.clr", overflow, 0);
    cyc(1, 8'hBB, 0, 1, 1, 0);
    chk("ovf.set_wins", overflow, 1);
    cyc(0, 0, 0, 1, 1, 0);
    chk("ovf.clr2", overflow, 0);
    cyc(1, 8'hEE, 1, 0, 1, 0);
    chk("flushpush.level", level, 0);
    chk("flushpush.empty", empty, 1);
    chk("flushpush.ovf", overflow, 0);
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0, 0, 1, 0);
    chk("refill.full", full, 1);
    cyc(1, 8'hCC, 0, 0, 0, 0);
    chk("fullpop.ovf", overflow, 1);
    chk("fullpop.level", level, 15);
    chk("fullpop.tx_en", tx_en, 1);
    chk("fullpop.tx_data", tx_data, 8'h10);

    // Flush while presenting
    cyc(0, 0, 1, 0, 0, 0);
    chk("flstart.tx_en", tx_en, 0);
    chk("flstart.level", level, 0);
    chk("flstart.empty", empty, 1);
    seen = 0;
    repeat (8) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (tx_en) seen = 1;
    end
    chk("flstart.no_tx_en", seen, 0);
    cyc(1, 8'h5A, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("flstart.idle_tx_en", tx_en, 1);
    chk("flstart.idle_data", tx_data, 8'h5A);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);

    // Flush while a byte is in flight
    cyc(1, 8'h11, 0, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0, 0);
    chk("flwait.tx_data", tx_data, 8'h11);
    cyc(1, 8'h33, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("flwait.pre_level", level, 2);
    cyc(0, 0, 1, 0, 1, 0);
    chk("flwait.level", level, 0);
    seen = 0;
    repeat (3) begin
      cyc(0, 0, 0, 0, 1, 0);
      if (tx_en) seen = 1;
    end
    cyc(0, 0, 0, 0, 0, 1);
    repeat (5) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (tx_en) seen = 1;
    end
    chk("flwait.no_pop", seen, 0);
    chk("flwait.hold_data", tx_data, 8'h11);
    cyc(1, 8'h44, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("flwait.idle_tx_en", tx_en, 1);
    chk("flwait.idle_data", tx_data, 8'h44);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);

    // Reset mid-transmission with bytes queued and overflow still set
    cyc(1, 8'h01, 0, 0, 0, 0);
    cyc(1, 8'h02, 0, 0, 0, 0);
    cyc(1, 8'h03, 0, 0, 1, 0);
    cyc(1, 8'h04, 0, 0, 1, 0);
    cyc(1, 8'h05, 0, 0, 1, 0);
    cyc(1, 8'h06, 0, 0, 1, 0);
    chk("rstmid.pre_level", level, 5);
    chk("rstmid.pre_ovf", overflow, 1);
    wr_en = 0;
    #2 PRESETn = 1'b0;
    #1;
    chk("rstmid.tx_en", tx_en, 0);
    chk("rstmid.level", level, 0);
    chk("rstmid.ovf", overflow, 0);
    chk("rstmid.empty", empty, 1);
    #2 PRESETn = 1'b1;
    cyc(1, 8'h99, 0, 0, 0, 0);
    chk("rstmid.post_level", level, 1);
    chk("rstmid.post_tx_en0", tx_en, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rstmid.post_tx_en", tx_en, 1);
    chk("rstmid.post_data", tx_data, 8'h99);

    // Randomised run against a queue-based model
    #2 PRESETn = 1'b0;
    #2 PRESETn = 1'b1;
    mq.delete(); ms = 0; mtxen = 0; movf = 0; mtxd = 0;
    for (int k = 0; k < 1500; k++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      flush   = ($urandom_range(0, 39) == 0);
      ovf_clr = ($urandom_range(0, 9) == 0);
      tx_busy = 1'($urandom_range(0, 1));
      tx_done = ($urandom_range(0, 3) == 0);

      mfull  = (mq.size() == DEPTH);
      mempty = (mq.size() == 0);
      mpop   = (ms == 0) && !mempty && !tx_busy && !flush;
      if (wr_en && mfull && !flush) movf = 1;
      else if (ovf_clr) movf = 0;
      if (flush) mq.delete();
      else begin
        if (mpop) mtxd = mq.pop_front();
        if (wr_en && !mfull) mq.push_back(wr_data);
      end
      case (ms)
        0: if (mpop) begin ms = 1; mtxen = 1; end
        1: if (flush) begin ms = 0; mtxen = 0; end
           else if (tx_busy) begin ms = 2; mtxen = 0; end
        default: if (tx_done) ms = 0;
      endcase
      mlvl = 5'(mq.size());

      @(posedge PCLK);
      #1;
      chk($sformatf("rand%0d{lvl,full,empty,ovf,en,data}", k),
          {15'd0, level, full, empty, overflow, tx_en, tx_data},
          {15'd0, mlvl, (mlvl == 5'd16), (mlvl == 5'd0), movf, mtxen, mtxd});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries; it SHALL be a power of two, 2 or more.
REQ-003 PCLK  input  1  clock; all logic on rising edge.
REQ-004 PRESETn  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  push request; one byte per cycle from the APB-side register write strobe.
REQ-006 wr_data  input  N  byte to push.
REQ-007 flush  input  1  synchronous FIFO clear.
REQ-008 ovf_clr  input  1  clears the overflow flag.
REQ-009 tx_busy  input  1  transmitter busy status.
REQ-010 tx_done  input  1  transmitter one-cycle completion pulse.
REQ-011 tx_data  output  N  registered byte presented to the transmitter.
REQ-012 tx_en  output  1  registered transmit request to the transmitter.
REQ-013 full, empty  output  1 each  FIFO status, combinational from the pointers.
REQ-014 level  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
REQ-015 overflow  output  1  sticky flag for a rejected push.

Function
REQ-016 FIFO: circular buffer with read and write pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty; pointers wrap modulo 2*DEPTH.
REQ-017 A push with full=0 SHALL write wr_data at wptr and increment wptr; level SHALL be updated on the next cycle.
REQ-018 A push with full=1 SHALL be dropped and SHALL set overflow on the next edge, even if a pop occurs in the same cycle.
REQ-019 A simultaneous push and pop with 0<level<DEPTH SHALL leave level unchanged.
REQ-020 A push and pop in the same cycle at level=1 SHALL NOT forward data; the pushed byte is popped on a later cycle.
REQ-021 overflow SHALL clear on ovf_clr; if ovf_clr and a rejected push occur in the same cycle, set SHALL win.
REQ-022 The FSM SHALL have states IDLE, START and WAIT.
REQ-023 IDLE: if empty=0, tx_busy=0 and flush=0, the block SHALL pop the head into tx_data, set tx_en=1 and go to START.
REQ-024 START: tx_en SHALL stay 1 until tx_busy=1 is sampled; tx_en SHALL then clear and the FSM SHALL go to WAIT.
REQ-025 WAIT: on tx_done=1 the FSM SHALL return to IDLE; a pending byte SHALL load on the following edge, giving at least one idle cycle between bytes.
REQ-026 Pop-to-tx_en latency SHALL be 0 cycles; tx_data and tx_en update on the same edge.
REQ-027 tx_data SHALL hold its value outside a pop.
REQ-028 flush SHALL reset both pointers on the next edge, giving level=0 and empty=1.
REQ-029 flush in START SHALL clear tx_en and return the FSM to IDLE.
REQ-030 flush in WAIT SHALL NOT affect the FSM; the in-flight byte completes.
REQ-031 flush and wr_en in the same cycle: flush SHALL win and the push is discarded without setting overflow.
REQ-032 A tx_done pulse outside WAIT SHALL be ignored.

Reset
REQ-033 PRESETn low SHALL asynchronously force state=IDLE, pointers=0, tx_en=0, tx_data=0 and overflow=0, giving empty=1, full=0 and level=0.
REQ-034 Reset mid-transmission SHALL abandon the byte; FIFO contents are undefined but unreadable.
REQ-035 Storage array contents SHALL NOT be reset.

Structure
REQ-036 The FSM state encoding (2-bit: IDLE, START, WAIT) SHALL be in a shared package, uart_pkg, along with default N and DEPTH.
REQ-037 The FIFO SHALL be a sub-module, uart_sync_fifo, with push, pop, data, full, empty, level and flush; it is reusable for the Rx path.
REQ-038 The top SHALL contain the FSM and the overflow logic.

Verification
REQ-039 Reset, then push 0x55 with tx_busy modelled: tx_en rises one edge after the push is registered with tx_data=0x55, holds until tx_busy=1, then clears; after tx_done, empty=1.
REQ-040 Push 16 bytes 0x00..0x0F with tx_busy held 1: full=1 and level=16; a 17th push (0xAA) -> overflow=1 and level stays 16; ovf_clr -> overflow=0.
REQ-041 Queue 0xA1, 0xB2, 0xC3 with a transmitter model: bytes are presented in order, one tx_en per byte, each new byte only after the previous tx_done.
REQ-042 Assert flush while in START with 3 bytes queued: tx_en=0 the next cycle, level=0, FSM=IDLE, and no further tx_en occurs.
REQ-043 Assert flush while in WAIT: the in-flight byte's tx_done is still honoured, FSM returns to IDLE, and no subsequent pop occurs.
REQ-044 Drop PRESETn mid-WAIT with 5 bytes queued: tx_en=0, level=0 and overflow=0 immediately, and the FSM restarts from IDLE after release.
